// File: rtl/ram_line_ctrl_pkg.sv
// Shared types and helpers for the line-granular RAM controller:
// beat-count derivation, FSM state encoding and the pattern-fill beat value.
package ram_line_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WCAP,
        ST_WAIT,
        ST_RESP
    } state_e;

    function automatic int unsigned beats_of(input int unsigned line_width,
                                             input int unsigned word_size);
        return line_width / word_size;
    endfunction

    // Beat index sits in the top two bits of the word, line address in the low bits.
    function automatic logic [63:0] pattern_word(input int unsigned k,
                                                 input logic [63:0] addr,
                                                 input int unsigned word_size);
        logic [63:0] hi;
        hi = 64'(k[1:0]) << (word_size - 2);
        return hi | addr;
    endfunction

endpackage

// File: rtl/ram_line_array.sv
// Single-port line storage: synchronous write, combinational read of the
// controller's latched line address. Contents are not reset.
module ram_line_array #(
    parameter int unsigned ADDR_SIZE  = 13,
    parameter int unsigned LINE_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_SIZE-1:0]  addr,
    input  logic [LINE_WIDTH-1:0] wdata,
    output logic [LINE_WIDTH-1:0] rdata
);

    logic [LINE_WIDTH-1:0] mem [2**ADDR_SIZE];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/ram_line_ctrl.sv
// Line-granular RAM controller behind the cache RAM port.
// Optional RAM_LINE_CTRL_PATTERN_FILL_EN: never-written lines read back as an address pattern.
module ram_line_ctrl
    import ram_line_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_SIZE  = 13,
    parameter int unsigned WORD_SIZE  = 16,
    parameter int unsigned LINE_WIDTH = 64,
    parameter int unsigned LATENCY    = 4
) (
    input  logic                  ram_clk,
    input  logic                  ram_rst_n,
    input  logic [ADDR_SIZE-1:0]  ram_addr,
    input  logic                  ram_rnw,
    input  logic                  ram_avalid,
    input  logic [WORD_SIZE-1:0]  ram_wdata,
    output logic [WORD_SIZE-1:0]  ram_rdata,
    output logic                  ram_ack,
    output logic                  ram_busy,
    output logic [LINE_WIDTH-1:0] data_backdoor
);

    localparam int unsigned BEATS  = beats_of(LINE_WIDTH, WORD_SIZE);
    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [LAT_W-1:0]  LAT_INIT  = LAT_W'(LATENCY - 1);

    state_e                state_q, state_d;
    logic [ADDR_SIZE-1:0]  addr_q, addr_d;
    logic                  rnw_q, rnw_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic [WORD_SIZE-1:0]  rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic [LINE_WIDTH-1:0] backdoor_q, backdoor_d;

    logic                  arr_we;
    logic [LINE_WIDTH-1:0] arr_rdata;
    logic                  line_valid;

    ram_line_array #(
        .ADDR_SIZE  (ADDR_SIZE),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_array (
        .clk   (ram_clk),
        .we    (arr_we),
        .addr  (addr_q),
        .wdata (line_d),
        .rdata (arr_rdata)
    );

`ifdef RAM_LINE_CTRL_PATTERN_FILL_EN
    logic [(2**ADDR_SIZE)-1:0] valid_q;

    always_ff @(posedge ram_clk or negedge ram_rst_n) begin
        if (!ram_rst_n) begin
            valid_q <= '0;
        end else if (arr_we) begin
            valid_q[addr_q] <= 1'b1;
        end
    end

    assign line_valid = valid_q[addr_q];
`else
    assign line_valid = 1'b1;
`endif

    function automatic logic [WORD_SIZE-1:0] sel_beat(input logic [LINE_WIDTH-1:0] line,
                                                      input logic [BEAT_W-1:0]     k,
                                                      input logic                  valid,
                                                      input logic [ADDR_SIZE-1:0]  a);
        logic [63:0] pw;
        pw = pattern_word(32'(k), 64'(a), WORD_SIZE);
        if (valid) begin
            return line[int'(k)*WORD_SIZE +: WORD_SIZE];
        end
        return pw[WORD_SIZE-1:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rnw_d      = rnw_q;
        beat_d     = beat_q;
        lat_d      = lat_q;
        line_d     = line_q;
        rdata_d    = '0;
        ack_d      = 1'b0;
        busy_d     = busy_q;
        backdoor_d = backdoor_q;
        arr_we     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ram_avalid) begin
                    addr_d = ram_addr;
                    rnw_d  = ram_rnw;
                    busy_d = 1'b1;
                    if (ram_rnw) begin
                        lat_d   = LAT_INIT;
                        state_d = ST_WAIT;
                    end else begin
                        line_d[WORD_SIZE-1:0] = ram_wdata;
                        beat_d  = BEAT_W'(1);
                        state_d = ST_WCAP;
                    end
                end
            end
            ST_WCAP: begin
                line_d[int'(beat_q)*WORD_SIZE +: WORD_SIZE] = ram_wdata;
                if (beat_q == LAST_BEAT) begin
                    // Commit on the last capture edge so a later read sees the new line.
                    arr_we     = 1'b1;
                    backdoor_d = line_d;
                    beat_d     = '0;
                    lat_d      = LAT_INIT;
                    state_d    = ST_WAIT;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    ack_d   = 1'b1;
                    beat_d  = '0;
                    state_d = ST_RESP;
                    if (rnw_q) begin
                        rdata_d = sel_beat(arr_rdata, '0, line_valid, addr_q);
                    end
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (!rnw_q || beat_q == LAST_BEAT) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    beat_d  = beat_q + 1'b1;
                    ack_d   = 1'b1;
                    rdata_d = sel_beat(arr_rdata, beat_q + 1'b1, line_valid, addr_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ram_clk or negedge ram_rst_n) begin
        if (!ram_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            rnw_q      <= 1'b0;
            beat_q     <= '0;
            lat_q      <= '0;
            line_q     <= '0;
            rdata_q    <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            backdoor_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rnw_q      <= rnw_d;
            beat_q     <= beat_d;
            lat_q      <= lat_d;
            line_q     <= line_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            backdoor_q <= backdoor_d;
        end
    end

    assign ram_rdata     = rdata_q;
    assign ram_ack       = ack_q;
    assign ram_busy      = busy_q;
    assign data_backdoor = backdoor_q;

endmodule
